// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the ID/EX pipeline register.
// Control bundle carried from decode into EX.
package id_ex_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int REG_AW_DEF  = 3;
  localparam int ALUOP_W_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  typedef struct packed {
    logic                   RegDst;
    logic                   ALUSrc;
    logic                   MemToReg;
    logic                   RegWrite;
    logic                   MemRead;
    logic                   MemWrite;
    logic                   Branch;
    logic [ALUOP_W_DEF-1:0] ALUOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t gate_ctrl(
    input ctrl_t c,
    input logic  v
  );
    return v ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-EX bundle for the ID/EX register.
// master = ID/EX-side driver, slave = the register itself.
interface id_ex_pipe_reg_if
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  logic               hit;
  logic               flush;
  logic               valid_in;
  logic [DATA_W-1:0]  adder_pc_in;
  logic [DATA_W-1:0]  read_data_1_in;
  logic [DATA_W-1:0]  read_data_2_in;
  logic [DATA_W-1:0]  sign_extended_immediate_in;
  logic [REG_AW-1:0]  rs_in;
  logic [REG_AW-1:0]  rt_in;
  logic [REG_AW-1:0]  rd_in;
  logic               RegDst_in;
  logic               ALUSrc_in;
  logic               MemToReg_in;
  logic               RegWrite_in;
  logic               MemRead_in;
  logic               MemWrite_in;
  logic               Branch_in;
  logic [ALUOP_W-1:0] ALUOp_in;

  logic               valid_out;
  logic [DATA_W-1:0]  adder_pc_out;
  logic [DATA_W-1:0]  read_data_1_out;
  logic [DATA_W-1:0]  read_data_2_out;
  logic [DATA_W-1:0]  sign_extended_immediate_out;
  logic [REG_AW-1:0]  rs_out;
  logic [REG_AW-1:0]  rt_out;
  logic [REG_AW-1:0]  rd_out;
  logic               RegDst_out;
  logic               ALUSrc_out;
  logic               MemToReg_out;
  logic               RegWrite_out;
  logic               MemRead_out;
  logic               MemWrite_out;
  logic               Branch_out;
  logic [ALUOP_W-1:0] ALUOp_out;

  logic               stall_req;
  logic [CNT_W-1:0]   bubble_count;
  logic [CNT_W-1:0]   hold_count;

  modport master (
    output hit, flush, valid_in,
    output adder_pc_in, read_data_1_in,
    output read_data_2_in,
    output sign_extended_immediate_in,
    output rs_in, rt_in, rd_in,
    output RegDst_in, ALUSrc_in,
    output MemToReg_in, RegWrite_in,
    output MemRead_in, MemWrite_in,
    output Branch_in, ALUOp_in,
    input  valid_out,
    input  adder_pc_out, read_data_1_out,
    input  read_data_2_out,
    input  sign_extended_immediate_out,
    input  rs_out, rt_out, rd_out,
    input  RegDst_out, ALUSrc_out,
    input  MemToReg_out, RegWrite_out,
    input  MemRead_out, MemWrite_out,
    input  Branch_out, ALUOp_out,
    input  stall_req,
    input  bubble_count, hold_count
  );

  modport slave (
    input  hit, flush, valid_in,
    input  adder_pc_in, read_data_1_in,
    input  read_data_2_in,
    input  sign_extended_immediate_in,
    input  rs_in, rt_in, rd_in,
    input  RegDst_in, ALUSrc_in,
    input  MemToReg_in, RegWrite_in,
    input  MemRead_in, MemWrite_in,
    input  Branch_in, ALUOp_in,
    output valid_out,
    output adder_pc_out, read_data_1_out,
    output read_data_2_out,
    output sign_extended_immediate_out,
    output rs_out, rt_out, rd_out,
    output RegDst_out, ALUSrc_out,
    output MemToReg_out, RegWrite_out,
    output MemRead_out, MemWrite_out,
    output Branch_out, ALUOp_out,
    output stall_req,
    output bubble_count, hold_count
  );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use compare: a valid load in EX whose rt feeds the
// instruction now in ID.
module load_use_detect #(
  parameter int REG_AW = 3
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = (ex_rt == id_rt);

  assign load_use = ex_valid & ex_mem_read
                  & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, miss hold and
// load-use bubble insertion; state moves on the falling edge.
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [CNT_W-1:0]  bubble_q;
  logic [CNT_W-1:0]  hold_q;
  logic              load_use;
  logic              take_data;
  logic              do_bubble;
  logic              do_hold;

  assign ctrl_in = '{
    RegDst:   bus.RegDst_in,
    ALUSrc:   bus.ALUSrc_in,
    MemToReg: bus.MemToReg_in,
    RegWrite: bus.RegWrite_in,
    MemRead:  bus.MemRead_in,
    MemWrite: bus.MemWrite_in,
    Branch:   bus.Branch_in,
    ALUOp:    ALUOP_W_DEF'(bus.ALUOp_in)
  };

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_lud (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.MemRead),
    .ex_rt       (rt_q),
    .id_valid    (bus.valid_in),
    .id_rs       (bus.rs_in),
    .id_rt       (bus.rt_in),
    .load_use    (load_use)
  );

  // Flush outranks a miss; a miss outranks a bubble.
  assign take_data = bus.flush | bus.hit;
  assign do_hold   = ~bus.flush & ~bus.hit;
  assign do_bubble = ~bus.flush & bus.hit & load_use;

  assign bus.stall_req = rst_n & load_use
                       & bus.hit & ~bus.flush;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      imm_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
    end else if (take_data) begin
      pc_q  <= bus.adder_pc_in;
      rd1_q <= bus.read_data_1_in;
      rd2_q <= bus.read_data_2_in;
      imm_q <= bus.sign_extended_immediate_in;
      rs_q  <= bus.rs_in;
      rt_q  <= bus.rt_in;
      rd_q  <= bus.rd_in;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end else if (!bus.hit) begin
      valid_q <= valid_q;
      ctrl_q  <= ctrl_q;
    end else if (load_use) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
    end else begin
      valid_q <= bus.valid_in;
      ctrl_q  <= gate_ctrl(ctrl_in, bus.valid_in);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      if (do_bubble && bubble_q != '1)
        bubble_q <= bubble_q + CNT_W'(1);
      if (do_hold && hold_q != '1)
        hold_q <= hold_q + CNT_W'(1);
    end
  end

  assign bus.valid_out    = valid_q;
  assign bus.adder_pc_out = pc_q;
  assign bus.read_data_1_out = rd1_q;
  assign bus.read_data_2_out = rd2_q;
  assign bus.sign_extended_immediate_out = imm_q;
  assign bus.rs_out       = rs_q;
  assign bus.rt_out       = rt_q;
  assign bus.rd_out       = rd_q;
  assign bus.RegDst_out   = ctrl_q.RegDst;
  assign bus.ALUSrc_out   = ctrl_q.ALUSrc;
  assign bus.MemToReg_out = ctrl_q.MemToReg;
  assign bus.RegWrite_out = ctrl_q.RegWrite;
  assign bus.MemRead_out  = ctrl_q.MemRead;
  assign bus.MemWrite_out = ctrl_q.MemWrite;
  assign bus.Branch_out   = ctrl_q.Branch;
  assign bus.ALUOp_out    = ALUOP_W'(ctrl_q.ALUOp);
  assign bus.bubble_count = bubble_q;
  assign bus.hold_count   = hold_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: vector table plus
// hold, flush, saturation and reset sequences.
module tb_id_ex_pipe_reg;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] RW   = 7'b0001000;
  localparam logic [6:0] LW   = 7'b0111100;
  localparam logic [6:0] ADD  = 7'b1001000;
  localparam logic [6:0] BR   = 7'b0000001;
  localparam logic [6:0] RWMW = 7'b0001100;

  typedef struct {
    logic        valid;
    logic [15:0] pc, rd1, rd2, imm;
    logic [2:0]  rs, rt, rd;
    logic [6:0]  ctrl;
    logic [1:0]  alu;
    logic        hit, flush;
    logic        e_stall, e_valid;
    logic [15:0] e_pc, e_rd1;
    logic [6:0]  e_ctrl;
    logic [1:0]  e_alu;
    logic [2:0]  e_rt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t tbl [9];

  id_ex_pipe_reg_if #(.CNT_W(16)) bus ();
  id_ex_pipe_reg_if #(.CNT_W(2))  sbus ();

  id_ex_pipe_reg #(
    .DATA_W(16), .REG_AW(3), .ALUOP_W(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  id_ex_pipe_reg #(
    .DATA_W(16), .REG_AW(3), .ALUOP_W(2), .CNT_W(2)
  ) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  assign sbus.hit          = bus.hit;
  assign sbus.flush        = bus.flush;
  assign sbus.valid_in     = bus.valid_in;
  assign sbus.adder_pc_in  = bus.adder_pc_in;
  assign sbus.read_data_1_in = bus.read_data_1_in;
  assign sbus.read_data_2_in = bus.read_data_2_in;
  assign sbus.sign_extended_immediate_in =
    bus.sign_extended_immediate_in;
  assign sbus.rs_in        = bus.rs_in;
  assign sbus.rt_in        = bus.rt_in;
  assign sbus.rd_in        = bus.rd_in;
  assign sbus.RegDst_in    = bus.RegDst_in;
  assign sbus.ALUSrc_in    = bus.ALUSrc_in;
  assign sbus.MemToReg_in  = bus.MemToReg_in;
  assign sbus.RegWrite_in  = bus.RegWrite_in;
  assign sbus.MemRead_in   = bus.MemRead_in;
  assign sbus.MemWrite_in  = bus.MemWrite_in;
  assign sbus.Branch_in    = bus.Branch_in;
  assign sbus.ALUOp_in     = bus.ALUOp_in;

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_out();
    return {bus.RegDst_out, bus.ALUSrc_out,
            bus.MemToReg_out, bus.RegWrite_out,
            bus.MemRead_out, bus.MemWrite_out,
            bus.Branch_out};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.valid_in       = v.valid;
    bus.adder_pc_in    = v.pc;
    bus.read_data_1_in = v.rd1;
    bus.read_data_2_in = v.rd2;
    bus.sign_extended_immediate_in = v.imm;
    bus.rs_in = v.rs;
    bus.rt_in = v.rt;
    bus.rd_in = v.rd;
    {bus.RegDst_in, bus.ALUSrc_in, bus.MemToReg_in,
     bus.RegWrite_in, bus.MemRead_in,
     bus.MemWrite_in, bus.Branch_in} = v.ctrl;
    bus.ALUOp_in = v.alu;
    bus.hit      = v.hit;
    bus.flush    = v.flush;
  endtask

  task automatic instr(input logic [15:0] pc,
                       input logic [2:0] rs,
                       input logic [2:0] rt,
                       input logic [6:0] ctrl,
                       input logic [1:0] alu,
                       input logic hit,
                       input logic flush);
    vec_t v;
    v = tbl[0];
    v.valid = 1'b1;
    v.pc = pc;
    v.rd1 = pc + 16'h0100;
    v.rd2 = pc + 16'h0200;
    v.imm = pc;
    v.rs = rs;
    v.rt = rt;
    v.rd = 3'd7;
    v.ctrl = ctrl;
    v.alu = alu;
    v.hit = hit;
    v.flush = flush;
    drive(v);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.valid_out), 0);
    chk({tag, "_pc"}, 32'(bus.adder_pc_out), 0);
    chk({tag, "_rd1"}, 32'(bus.read_data_1_out), 0);
    chk({tag, "_imm"},
        32'(bus.sign_extended_immediate_out), 0);
    chk({tag, "_rt"}, 32'(bus.rt_out), 0);
    chk({tag, "_ctrl"}, 32'(ctrl_out()), 0);
    chk({tag, "_alu"}, 32'(bus.ALUOp_out), 0);
    chk({tag, "_bcnt"}, 32'(bus.bubble_count), 0);
    chk({tag, "_hcnt"}, 32'(bus.hold_count), 0);
    chk({tag, "_sbcnt"}, 32'(sbus.bubble_count), 0);
    chk({tag, "_shcnt"}, 32'(sbus.hold_count), 0);
    chk({tag, "_stall"}, 32'(bus.stall_req), 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{1'b1, 16'h0042, 16'h1111, 16'h2222,
      16'h0005, 3'd1, 3'd2, 3'd4, RW, 2'b10, 1'b1,
      1'b0, 1'b0, 1'b1, 16'h0042, 16'h1111, RW,
      2'b10, 3'd2};
    tbl[1] = '{1'b0, 16'h0044, 16'h3333, 16'h4444,
      16'h0006, 3'd5, 3'd6, 3'd1, RWMW, 2'b01, 1'b1,
      1'b0, 1'b0, 1'b0, 16'h0044, 16'h3333, NONE,
      2'b00, 3'd6};
    tbl[2] = '{1'b1, 16'h0046, 16'h0100, 16'h0101,
      16'h0008, 3'd1, 3'd3, 3'd0, LW, 2'b00, 1'b1,
      1'b0, 1'b0, 1'b1, 16'h0046, 16'h0100, LW,
      2'b00, 3'd3};
    tbl[3] = '{1'b1, 16'h0048, 16'h0200, 16'h0201,
      16'h0000, 3'd3, 3'd5, 3'd7, ADD, 2'b10, 1'b1,
      1'b0, 1'b1, 1'b0, 16'h0048, 16'h0200, NONE,
      2'b00, 3'd5};
    tbl[4] = '{1'b1, 16'h0048, 16'h0200, 16'h0201,
      16'h0000, 3'd3, 3'd5, 3'd7, ADD, 2'b10, 1'b1,
      1'b0, 1'b0, 1'b1, 16'h0048, 16'h0200, ADD,
      2'b10, 3'd5};
    tbl[5] = '{1'b1, 16'h004A, 16'h0300, 16'h0301,
      16'h0010, 3'd4, 3'd2, 3'd2, LW, 2'b00, 1'b1,
      1'b0, 1'b0, 1'b1, 16'h004A, 16'h0300, LW,
      2'b00, 3'd2};
    tbl[6] = '{1'b1, 16'h004C, 16'h0400, 16'h0401,
      16'h0001, 3'd1, 3'd2, 3'd3, ADD, 2'b10, 1'b1,
      1'b0, 1'b1, 1'b0, 16'h004C, 16'h0400, NONE,
      2'b00, 3'd2};
    tbl[7] = '{1'b1, 16'h004E, 16'h0500, 16'h0501,
      16'hFFFE, 3'd6, 3'd7, 3'd0, BR, 2'b01, 1'b1,
      1'b0, 1'b0, 1'b1, 16'h004E, 16'h0500, BR,
      2'b01, 3'd7};
    tbl[8] = '{1'b1, 16'h0050, 16'h0600, 16'h0601,
      16'h0002, 3'd0, 3'd1, 3'd5, ADD, 2'b10, 1'b1,
      1'b1, 1'b0, 1'b0, 16'h0050, 16'h0600, NONE,
      2'b00, 3'd1};

    rst_n = 1'b0;
    drive(tbl[0]);
    tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i),
          32'(bus.stall_req), 32'(tbl[i].e_stall));
      tick();
      chk($sformatf("v%0d_valid", i),
          32'(bus.valid_out), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_pc", i),
          32'(bus.adder_pc_out), 32'(tbl[i].e_pc));
      chk($sformatf("v%0d_rd1", i),
          32'(bus.read_data_1_out), 32'(tbl[i].e_rd1));
      chk($sformatf("v%0d_rd2", i),
          32'(bus.read_data_2_out), 32'(tbl[i].rd2));
      chk($sformatf("v%0d_imm", i),
          32'(bus.sign_extended_immediate_out),
          32'(tbl[i].imm));
      chk($sformatf("v%0d_rs", i),
          32'(bus.rs_out), 32'(tbl[i].rs));
      chk($sformatf("v%0d_rt", i),
          32'(bus.rt_out), 32'(tbl[i].e_rt));
      chk($sformatf("v%0d_rd", i),
          32'(bus.rd_out), 32'(tbl[i].rd));
      chk($sformatf("v%0d_ctrl", i),
          32'(ctrl_out()), 32'(tbl[i].e_ctrl));
      chk($sformatf("v%0d_alu", i),
          32'(bus.ALUOp_out), 32'(tbl[i].e_alu));
    end
    chk("tbl_bcnt", 32'(bus.bubble_count), 2);
    chk("tbl_hcnt", 32'(bus.hold_count), 0);

    // miss hold with a load-use pattern waiting in ID
    instr(16'h0060, 3'd1, 3'd3, LW, 2'b00, 1'b1, 1'b0);
    tick();
    chk("hold_pre_valid", 32'(bus.valid_out), 1);
    for (int k = 0; k < 4; k++) begin
      instr(16'h0062 + 16'(2 * k), 3'd3, 3'd4, ADD,
            2'b10, 1'b0, 1'b0);
      #1;
      chk($sformatf("hold%0d_stall", k),
          32'(bus.stall_req), 0);
      tick();
      chk($sformatf("hold%0d_pc", k),
          32'(bus.adder_pc_out), 32'h0060);
      chk($sformatf("hold%0d_valid", k),
          32'(bus.valid_out), 1);
      chk($sformatf("hold%0d_ctrl", k),
          32'(ctrl_out()), 32'(LW));
    end
    chk("hold_hcnt", 32'(bus.hold_count), 4);
    chk("hold_bcnt", 32'(bus.bubble_count), 2);

    instr(16'h0070, 3'd3, 3'd4, ADD, 2'b10, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(bus.stall_req), 1);
    tick();
    chk("lu_bub_valid", 32'(bus.valid_out), 0);
    chk("lu_bub_ctrl", 32'(ctrl_out()), 0);
    chk("lu_bub_alu", 32'(bus.ALUOp_out), 0);
    chk("lu_bub_bcnt", 32'(bus.bubble_count), 3);
    chk("lu_rel_stall", 32'(bus.stall_req), 0);
    tick();
    chk("lu_add_valid", 32'(bus.valid_out), 1);
    chk("lu_add_ctrl", 32'(ctrl_out()), 32'(ADD));
    chk("lu_add_alu", 32'(bus.ALUOp_out), 32'h2);
    chk("lu_add_pc", 32'(bus.adder_pc_out), 32'h0070);

    // flush beats both a miss and a load-use
    instr(16'h0080, 3'd1, 3'd3, LW, 2'b00, 1'b1, 1'b0);
    tick();
    chk("fl_pre_valid", 32'(bus.valid_out), 1);
    instr(16'h0082, 3'd3, 3'd5, ADD, 2'b10, 1'b0, 1'b1);
    #1;
    chk("fl_stall", 32'(bus.stall_req), 0);
    tick();
    chk("fl_valid", 32'(bus.valid_out), 0);
    chk("fl_ctrl", 32'(ctrl_out()), 0);
    chk("fl_alu", 32'(bus.ALUOp_out), 0);
    chk("fl_bcnt", 32'(bus.bubble_count), 3);
    chk("fl_hcnt", 32'(bus.hold_count), 4);

    // a self-dependent load alternates load / bubble
    instr(16'h0090, 3'd3, 3'd3, LW, 2'b00, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("sat%0d_valid", k),
          32'(bus.valid_out), 32'((k % 2) == 0));
      chk($sformatf("sat%0d_sbcnt", k),
          32'(sbus.bubble_count), 3);
    end
    chk("sat_bcnt", 32'(bus.bubble_count), 8);
    chk("sat_shcnt", 32'(sbus.hold_count), 3);

    // asynchronous reset in the middle of a hold
    instr(16'h00A0, 3'd1, 3'd2, ADD, 2'b10, 1'b0, 1'b0);
    tick();
    chk("mid_hcnt", 32'(bus.hold_count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    tick();
    chk_all_zero("arst_edge");
    rst_n = 1'b1;
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
